s_axil_regfile: RTL and testbench

// Parametrised AXI4-Lite slave register bank; successor to the fixed 6-entry slave register block.

---
 rtl/axil_pkg.sv | 14 +
 rtl/axil_addr_decode.sv | 27 ++
 rtl/s_axil_regfile.sv | 209 ++++++++++++++++++++
 tb/tb_s_axil_regfile.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite register-bank definitions: response codes, channel FSM states and fixed register slots.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  localparam int REG_CTRL   = 0;
  localparam int REG_STATUS = 1;

endpackage

// File: rtl/axil_addr_decode.sv
// Combinational byte-address to register-index decode; zero latency, no flow control.
// Addresses below BASE_ADDR or past the bank, or not word aligned, report a miss.
module axil_addr_decode #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    REG_COUNT  = 6,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'hA3DD0000),
  parameter int                    IDX_W      = $clog2(REG_COUNT)
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  hit_o,
  output logic [IDX_W-1:0]      idx_o
);

  localparam logic [ADDR_WIDTH-1:0] BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(REG_COUNT * (DATA_WIDTH / 8));

  logic [ADDR_WIDTH-1:0] off;

  always_comb begin
    off = addr_i - BASE_ADDR;
    // The explicit lower-bound test stops a wrapped subtraction from aliasing into the bank.
    hit_o = (addr_i >= BASE_ADDR) && (off < SPAN) && ((off % BYTES) == '0);
    idx_o = IDX_W'(off / BYTES);
  end

endmodule

// File: rtl/s_axil_regfile.sv
// AXI4-Lite slave register bank: B one cycle after both AW and W are held, R one cycle after AR.
// Each channel holds its response until accepted and stalls new requests on that channel meanwhile.
module s_axil_regfile
  import axil_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    REG_COUNT  = 6,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'hA3DD0000)
) (
  input  logic                            clk,
  input  logic                            areset,
  input  logic [ADDR_WIDTH-1:0]           awaddr_i,
  input  logic                            awvalid_i,
  output logic                            awready_o,
  input  logic [DATA_WIDTH-1:0]           wdata_i,
  input  logic [DATA_WIDTH/8-1:0]         wstrb_i,
  input  logic                            wvalid_i,
  output logic                            wready_o,
  output logic [1:0]                      bresp_o,
  output logic                            bvalid_o,
  input  logic                            bready_i,
  input  logic [ADDR_WIDTH-1:0]           araddr_i,
  input  logic                            arvalid_i,
  output logic                            arready_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic [1:0]                      rresp_o,
  output logic                            rvalid_o,
  input  logic                            rready_i,
  output logic [REG_COUNT*DATA_WIDTH-1:0] regs_o,
  input  logic [DATA_WIDTH-1:0]           status_i,
  output logic                            start_o
);

  localparam int                STRB_W     = DATA_WIDTH / 8;
  localparam int                IDX_W      = $clog2(REG_COUNT);
  localparam logic [IDX_W-1:0]  IDX_CTRL   = IDX_W'(REG_CTRL);
  localparam logic [IDX_W-1:0]  IDX_STATUS = IDX_W'(REG_STATUS);

  wr_state_t             w_state_q;
  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  bvalid_q, start_q, start_d;
  logic [1:0]            bresp_q, bresp_d;

  rd_state_t             r_state_q;
  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] aw_addr_eff;
  logic [DATA_WIDTH-1:0] wdata_eff;
  logic [STRB_W-1:0]     wstrb_eff;
  logic                  aw_hit, ar_hit;
  logic [IDX_W-1:0]      aw_idx, ar_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  assign awready_o = (w_state_q == W_IDLE) && !aw_held_q;
  assign wready_o  = (w_state_q == W_IDLE) && !w_held_q;
  assign arready_o = (r_state_q == R_IDLE);
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;
  assign start_o   = start_q;
  assign rvalid_o  = rvalid_q;
  assign rresp_o   = rresp_q;
  assign rdata_o   = rdata_q;

  assign aw_hs = awvalid_i && awready_o;
  assign w_hs  = wvalid_i && wready_o;
  assign ar_hs = arvalid_i && arready_o;

  // A beat arriving this cycle is used directly so AW+W together commit without a bubble.
  assign aw_addr_eff = aw_held_q ? awaddr_q : awaddr_i;
  assign wdata_eff   = w_held_q ? wdata_q : wdata_i;
  assign wstrb_eff   = w_held_q ? wstrb_q : wstrb_i;
  assign commit      = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

  axil_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .REG_COUNT(REG_COUNT),
    .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
  ) u_aw_decode (
    .addr_i(aw_addr_eff),
    .hit_o (aw_hit),
    .idx_o (aw_idx)
  );

  axil_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .REG_COUNT(REG_COUNT),
    .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
  ) u_ar_decode (
    .addr_i(araddr_i),
    .hit_o (ar_hit),
    .idx_o (ar_idx)
  );

  always_comb begin
    regs_d  = regs_q;
    bresp_d = RESP_OKAY;
    start_d = 1'b0;
    if (commit) begin
      if (!aw_hit) begin
        bresp_d = RESP_DECERR;
      end else if (aw_idx == IDX_STATUS) begin
        bresp_d = RESP_SLVERR;
      end else begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wstrb_eff[b]) regs_d[aw_idx][b*8 +: 8] = wdata_eff[b*8 +: 8];
        end
        if (aw_idx == IDX_CTRL) begin
          start_d = wstrb_eff[0] && wdata_eff[0];
          regs_d[IDX_CTRL][0] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      start_q   <= 1'b0;
    end else begin
      start_q <= start_d;
      case (w_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held_q <= 1'b1;
            awaddr_q  <= awaddr_i;
          end
          if (w_hs) begin
            w_held_q <= 1'b1;
            wdata_q  <= wdata_i;
            wstrb_q  <= wstrb_i;
          end
          if (commit) begin
            bvalid_q  <= 1'b1;
            bresp_q   <= bresp_d;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (bready_i) begin
            bvalid_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Reads sample regs_q, so a same-edge write is not yet visible.
  assign rd_word = (ar_idx == IDX_STATUS) ? status_i : regs_q[ar_idx];

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            rvalid_q  <= 1'b1;
            rdata_q   <= ar_hit ? rd_word : '0;
            rresp_q   <= ar_hit ? RESP_OKAY : RESP_DECERR;
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready_i) begin
            rvalid_q  <= 1'b0;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Slot 1 has no storage; its live value is only visible through the read channel.
  for (genvar i = 0; i < REG_COUNT; i++) begin : g_regs_o
    assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

endmodule

// File: tb/tb_s_axil_regfile.sv
// Scoreboard bench for s_axil_regfile: issued transactions queue expected B/R responses, a monitor checks them.
module tb_s_axil_regfile;

  localparam logic [31:0] BASE = 32'hA3DD0000;

  logic         clk = 1'b0;
  logic         areset = 1'b1;
  logic [31:0]  awaddr_i = '0;
  logic         awvalid_i = 1'b0;
  logic         awready_o;
  logic [31:0]  wdata_i = '0;
  logic [3:0]   wstrb_i = '0;
  logic         wvalid_i = 1'b0;
  logic         wready_o;
  logic [1:0]   bresp_o;
  logic         bvalid_o;
  logic         bready_i = 1'b1;
  logic [31:0]  araddr_i = '0;
  logic         arvalid_i = 1'b0;
  logic         arready_o;
  logic [31:0]  rdata_o;
  logic [1:0]   rresp_o;
  logic         rvalid_o;
  logic         rready_i = 1'b1;
  logic [191:0] regs_o;
  logic [31:0]  status_i = '0;
  logic         start_o;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic [31:0] mreg[6];

  s_axil_regfile dut (
    .clk(clk), .areset(areset),
    .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .regs_o(regs_o), .status_i(status_i), .start_o(start_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [191:0] image();
    return {mreg[5], mreg[4], mreg[3], mreg[2], mreg[1], mreg[0]};
  endfunction

  // Monitor: pops expectations as the DUT completes B and R handshakes, and polices start_o.
  initial begin : monitor
    logic prev_bvalid;
    logic prev_start;
    logic [33:0] e;
    prev_bvalid = 1'b0;
    prev_start  = 1'b0;
    forever begin
      @(negedge clk);
      if (bvalid_o && bready_i) begin
        if (exp_b.size() == 0) chk("unexpected_b", 192'(bvalid_o), 192'(0));
        else chk("bresp", 192'(bresp_o), 192'(exp_b.pop_front()));
      end
      if (rvalid_o && rready_i) begin
        if (exp_r.size() == 0) chk("unexpected_r", 192'(rvalid_o), 192'(0));
        else begin
          e = exp_r.pop_front();
          chk("rdata", 192'(rdata_o), 192'(e[33:2]));
          chk("rresp", 192'(rresp_o), 192'(e[1:0]));
        end
      end
      if (start_o) begin
        start_cnt++;
        chk("start_on_b_rise", 192'({bvalid_o, prev_bvalid, prev_start}), 192'(3'b100));
      end
      prev_bvalid = bvalid_o;
      prev_start  = start_o;
    end
  end

  task automatic send_aw(input logic [31:0] a);
    int n = 0;
    awaddr_i = a; awvalid_i = 1'b1;
    @(negedge clk);
    while (!awready_o && n < 50) begin n++; @(negedge clk); end
    if (!awready_o) chk("aw_timeout", 192'(awready_o), 192'(1));
    @(posedge clk); #1; awvalid_i = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wdata_i = d; wstrb_i = s; wvalid_i = 1'b1;
    @(negedge clk);
    while (!wready_o && n < 50) begin n++; @(negedge clk); end
    if (!wready_o) chk("w_timeout", 192'(wready_o), 192'(1));
    @(posedge clk); #1; wvalid_i = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    int n = 0;
    araddr_i = a; arvalid_i = 1'b1;
    @(negedge clk);
    while (!arready_o && n < 50) begin n++; @(negedge clk); end
    if (!arready_o) chk("ar_timeout", 192'(arready_o), 192'(1));
    @(posedge clk); #1; arvalid_i = 1'b0;
  endtask

  task automatic wait_b();
    int n = 0;
    while (exp_b.size() != 0 && n < 100) begin @(posedge clk); n++; end
    if (exp_b.size() != 0) begin
      chk("b_timeout", 192'(exp_b.size()), 192'(0));
      exp_b.delete();
    end
    #1;
  endtask

  task automatic wait_r();
    int n = 0;
    while (exp_r.size() != 0 && n < 100) begin @(posedge clk); n++; end
    if (exp_r.size() != 0) begin
      chk("r_timeout", 192'(exp_r.size()), 192'(0));
      exp_r.delete();
    end
    #1;
  endtask

  // mode 0: AW+W together, 1: AW then W two cycles later, 2: W then AW
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] er, input int mode);
    int idx;
    exp_b.push_back(er);
    case (mode)
      0: fork send_aw(a); send_w(d, s); join
      1: begin send_aw(a); repeat (2) @(posedge clk); #1; send_w(d, s); end
      default: begin send_w(d, s); send_aw(a); end
    endcase
    wait_b();
    if (er == 2'b00) begin
      idx = int'((a - BASE) >> 2);
      for (int b = 0; b < 4; b++) if (s[b]) mreg[idx][b*8 +: 8] = d[b*8 +: 8];
      if (idx == 0) mreg[0][0] = 1'b0;
    end
    chk("regs_o", regs_o, image());
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] er);
    exp_r.push_back({d, er});
    send_ar(a);
    wait_r();
  endtask

  initial begin
    for (int i = 0; i < 6; i++) mreg[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_regs", regs_o, 192'(0));
    chk("rst_ready", 192'({awready_o, wready_o, arready_o}), 192'(3'b111));
    chk("rst_valid", 192'({bvalid_o, rvalid_o, start_o}), 192'(0));
    chk("rst_resp", 192'({bresp_o, rresp_o, rdata_o}), 192'(0));
    @(posedge clk); #1; areset = 1'b0;
    @(posedge clk); #1;

    wr(BASE + 32'hC, 32'h4, 4'hF, 2'b00, 1);
    rd(BASE + 32'hC, 32'h4, 2'b00);
    chk("reg3_slice", 192'(regs_o[127:96]), 192'(32'h4));

    wr(BASE + 32'h8, 32'hA3DD0014, 4'b0011, 2'b00, 2);
    chk("reg2_slice", 192'(regs_o[95:64]), 192'(32'h00000014));
    rd(BASE + 32'h8, 32'h00000014, 2'b00);

    wr(BASE + 32'h18, 32'hFFFFFFFF, 4'hF, 2'b11, 0);
    wr(BASE + 32'h1, 32'hFFFFFFFF, 4'hF, 2'b11, 0);
    wr(32'hA3DCFFFC, 32'hFFFFFFFF, 4'hF, 2'b11, 1);
    rd(BASE + 32'h18, 32'h0, 2'b11);
    rd(BASE + 32'h17, 32'h0, 2'b11);

    status_i = 32'h5;
    wr(BASE + 32'h4, 32'hDEADBEEF, 4'hF, 2'b10, 0);
    rd(BASE + 32'h4, 32'h5, 2'b00);

    wr(BASE, 32'h1, 4'hF, 2'b00, 0);
    rd(BASE, 32'h0, 2'b00);
    wr(BASE, 32'h103, 4'hF, 2'b00, 2);
    rd(BASE, 32'h102, 2'b00);
    wr(BASE, 32'h1, 4'b1110, 2'b00, 0);
    rd(BASE, 32'h2, 2'b00);
    chk("start_count", 192'(start_cnt), 192'(2));

    wr(BASE + 32'h14, 32'h12345678, 4'h0, 2'b00, 0);

    fork
      wr(BASE + 32'h10, 32'h55, 4'hF, 2'b00, 0);
      rd(BASE + 32'h10, 32'h0, 2'b00);
    join
    rd(BASE + 32'h10, 32'h55, 2'b00);

    bready_i = 1'b0;
    exp_b.push_back(2'b00);
    fork send_aw(BASE + 32'hC); send_w(32'h77, 4'hF); join
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", 192'({bvalid_o, bresp_o, awready_o}), 192'(4'b1000));
    end
    @(posedge clk); #1; bready_i = 1'b1;
    wait_b();
    mreg[3] = 32'h77;
    chk("bp_regs", regs_o, image());

    rready_i = 1'b0;
    send_ar(BASE + 32'hC);
    @(negedge clk);
    chk("rvalid_held", 192'({rvalid_o, rdata_o}), 192'({1'b1, 32'h77}));
    areset = 1'b1;
    #1;
    chk("mid_rst_valid", 192'({rvalid_o, bvalid_o}), 192'(0));
    chk("mid_rst_regs", regs_o, 192'(0));
    @(posedge clk); #1;
    areset = 1'b0; rready_i = 1'b1;
    for (int i = 0; i < 6; i++) mreg[i] = '0;
    rd(BASE + 32'hC, 32'h0, 2'b00);

    repeat (3) @(posedge clk);
    chk("queues_drained", 192'(exp_b.size() + exp_r.size()), 192'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
